// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner. It debounces the source select,
// takes one 16-bit snapshot per frame and scans the digits on a prescaled slot counter.
module ssd_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int DEB_CYC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_val,
  input  logic [31:0] reg_val,
  input  logic        sel_raw,
  output logic [3:0]  AN,
  output logic [6:0]  SSD_out,
  output logic        src_pc,
  output logic        frame_done
);

  localparam int            CW       = $clog2(TICK_DIV);
  localparam int            DW       = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   frm;
  logic [1:0]    sync;
  logic [DW-1:0] deb_cnt;

  logic          snap;
  logic          blank;
  logic [15:0]   frm_disp;
  logic [3:0]    nib;
  logic [3:0]    an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // On the snapshot cycle the incoming value is decoded directly, so the first
  // displayed cycle of digit 0 already shows the new frame.
  always_comb begin
    snap     = (cnt == '0) && (dig == 2'd0);
    frm_disp = snap ? (src_pc ? pc_val[15:0] : reg_val[15:0]) : frm;
    blank    = int'(cnt) < BLANK_CYC;
    an_nxt   = 4'b1111;
    nib      = 4'h0;
    case (dig)
      2'd0: begin an_nxt = 4'b0111; nib = frm_disp[15:12]; end
      2'd1: begin an_nxt = 4'b1011; nib = frm_disp[11:8];  end
      2'd2: begin an_nxt = 4'b1101; nib = frm_disp[7:4];   end
      default: begin an_nxt = 4'b1110; nib = frm_disp[3:0]; end
    endcase
  end

  // NOTE: every register here, the frame snapshot included, is cleared by reset
  // and updated with non-blocking assignments so all state moves on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      dig        <= 2'd0;
      frm        <= 16'h0000;
      sync       <= 2'b00;
      deb_cnt    <= '0;
      src_pc     <= 1'b0;
      frame_done <= 1'b0;
      AN         <= 4'b1111;
      SSD_out    <= 7'b1111111;
    end else begin
      sync <= {sync[0], sel_raw};

      // Counter only runs while the synchronised select disagrees with src_pc.
      if (sync[1] == src_pc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        src_pc  <= sync[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (snap) frm <= frm_disp;

      frame_done <= (cnt == CNT_LAST) && (dig == 2'd3);
      AN         <= blank ? 4'b1111 : an_nxt;
      SSD_out    <= blank ? 7'b1111111 : hex7(nib);
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: stimulus queues expected display runs
// (anode, segments, length) and a negedge monitor compares each finished run.
module tb_ssd_scan_ctrl;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         len;
  } run_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_val;
  logic [31:0] reg_val;
  logic        sel_raw;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        src_a, src_b;
  logic        fd_a, fd_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  run_t exp_q[$];
  bit   mon_en = 1'b0;
  bit   mon_sel = 1'b0;

  logic [3:0] an_s, run_an;
  logic [6:0] seg_s, run_seg;
  int         run_len = 0;
  bit         run_valid = 1'b0;
  run_t       e;

  ssd_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2), .DEB_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .pc_val(pc_val), .reg_val(reg_val), .sel_raw(sel_raw),
    .AN(an_a), .SSD_out(seg_a), .src_pc(src_a), .frame_done(fd_a)
  );

  ssd_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(0), .DEB_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .pc_val(pc_val), .reg_val(reg_val), .sel_raw(sel_raw),
    .AN(an_b), .SSD_out(seg_b), .src_pc(src_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_run(input logic [3:0] an, input logic [6:0] seg, input int len);
    run_t r;
    r.an = an; r.seg = seg; r.len = len;
    exp_q.push_back(r);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int blank_len);
    if (blank_len > 0) push_run(4'b1111, 7'b1111111, blank_len);
    push_run(4'b0111, s0, 8 - blank_len);
    if (blank_len > 0) push_run(4'b1111, 7'b1111111, blank_len);
    push_run(4'b1011, s1, 8 - blank_len);
    if (blank_len > 0) push_run(4'b1111, 7'b1111111, blank_len);
    push_run(4'b1101, s2, 8 - blank_len);
    if (blank_len > 0) push_run(4'b1111, 7'b1111111, blank_len);
    push_run(4'b1110, s3, 8 - blank_len);
  endtask

  task automatic wait_frame(input bit use_b);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if ((use_b ? fd_b : fd_a) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL frame_timeout: no frame_done within 100 cycles (t=%0t)", $time);
    end
  endtask

  task automatic drain();
    bit empty = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    if (!empty) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d expected runs never seen", exp_q.size());
    end
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: a run is a stretch of identical (AN, SSD_out); it is compared when it ends.
  always @(negedge clk) begin
    an_s  = mon_sel ? an_b : an_a;
    seg_s = mon_sel ? seg_b : seg_a;
    if (run_len != 0 && an_s == run_an && seg_s == run_seg) begin
      run_len++;
    end else begin
      if (run_len != 0 && run_valid && mon_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_run: an %b seg %b len %0d", run_an, run_seg, run_len);
        end else begin
          e = exp_q.pop_front();
          check("run_an", 32'(run_an), 32'(e.an));
          check("run_seg", 32'(run_seg), 32'(e.seg));
          check("run_len", run_len, e.len);
        end
      end
      run_an    = an_s;
      run_seg   = seg_s;
      run_len   = 1;
      run_valid = mon_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int k;
    bit seen_hi;
    int blanks;

    rst = 1'b1; sel_raw = 1'b0; reg_val = 32'h0000_1234; pc_val = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_an", 32'(an_a), 32'b1111);
    check("reset_seg", 32'(seg_a), 32'b1111111);
    check("reset_src_pc", 32'(src_a), 0);
    rst = 1'b0;

    // Run into digit 2 (output j=19 shows "3"), then reset mid-scan for 3 cycles.
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_an", 32'(an_a), 32'b1101);
    check("pre_reset_seg", 32'(seg_a), 32'b0000110);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midscan_an", 32'(an_a), 32'b1111);
      check("midscan_seg", 32'(seg_a), 32'b1111111);
      check("midscan_fd", 32'(fd_a), 0);
      check("midscan_src_pc", 32'(src_a), 0);
      check("midscan_an_b", 32'(an_b), 32'b1111);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (an_a != 4'b1111) begin
        k = i;
        break;
      end
    end
    check("first_lit_latency", k, 3);
    check("first_lit_an", 32'(an_a), 32'b0111);

    // Scan order and snapshot stability: 1234, 1234 (reg changes in dig1), then ABCD.
    wait_frame(1'b0);
    t1 = cyc;
    mon_en = 1'b1;
    push_frame(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 2);
    push_frame(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 2);
    push_frame(7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 2);
    wait_frame(1'b0);
    check("frame_period", cyc - t1, 32);
    @(posedge clk); #1;
    check("fd_one_cycle", 32'(fd_a), 0);
    repeat (9) @(posedge clk);
    #1 reg_val = 32'h0000_ABCD;
    drain();

    // Debounce: 3-cycle glitch is rejected, a held level lands after 6 edges.
    @(posedge clk);
    #1 sel_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1 sel_raw = 1'b0;
    seen_hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen_hi |= src_a;
    end
    check("glitch_src_pc", 32'(seen_hi), 0);
    pc_val = 32'h0040_0020; sel_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("deb_src_pc_5", 32'(src_a), 0);
    @(posedge clk);
    #1 check("deb_src_pc_6", 32'(src_a), 1);
    wait_frame(1'b0);
    mon_en = 1'b1;
    push_frame(7'b0000001, 7'b0000001, 7'b0010010, 7'b0000001, 2);
    drain();

    // Back to register source, then land src_pc 0->1 on the snapshot edge.
    sel_raw = 1'b0; reg_val = 32'h0000_BEEF;
    repeat (10) @(posedge clk);
    #1 check("back_to_reg", 32'(src_a), 0);
    wait_frame(1'b0);
    repeat (27) @(posedge clk);
    #1 sel_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("boundary_fd", 32'(fd_a), 1);
    check("boundary_src_old", 32'(src_a), 0);
    mon_en = 1'b1;
    push_frame(7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000, 2);
    push_frame(7'b0000001, 7'b0000001, 7'b0010010, 7'b0000001, 2);
    @(posedge clk);
    #1 check("boundary_src_new", 32'(src_a), 1);
    drain();

    // No blanking: every digit is lit for the whole slot.
    mon_sel = 1'b1;
    wait_frame(1'b1);
    pc_val = 32'h0000_C9E7;
    mon_en = 1'b1;
    push_frame(7'b0110001, 7'b0000100, 7'b0110000, 7'b0001111, 0);
    blanks = 0;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #1;
      if (an_b == 4'b1111) blanks++;
    end
    check("noblank_count", blanks, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Drives the 4-digit common-anode seven-segment display shared by the PC and register-readout debug sources of the pipeline core.
- Picks one source using a debounced select switch and snapshots its low 16 bits once per frame, so digits never tear.
- Scans the digits with a clock-enable prescaler instead of a derived clock, and blanks each digit slot briefly against ghosting.
- Runs entirely in the system clock domain.

Parameters:
- TICK_DIV, 100000: clock cycles per digit slot; must be >= 2.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYC < TICK_DIV.
- DEB_CYC, 8: consecutive stable cycles needed on the synchronised select before src_pc changes; must be >= 1.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- pc_val  in  32  PC value from the core; only bits [15:0] are displayed.
- reg_val  in  32  register-readout value from the core; only bits [15:0] are displayed.
- sel_raw  in  1  raw, asynchronous switch: 1 = PC, 0 = register.
- AN  out  4  anode enables, active low.
- SSD_out  out  7  segments {a,b,c,d,e,f,g}, active low.
- src_pc  out  1  debounced source select currently in force for snapshots.
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- Reset values, from the first clock edge with rst=1: AN=1111, SSD_out=1111111, src_pc=0, frame_done=0, slot counter cnt=0, digit index dig=0, frame register frm=0, synchroniser=0, debounce counter=0. Reset mid-scan aborts the frame immediately.
- cnt counts 0..TICK_DIV-1 every cycle when rst=0. When it wraps, dig advances 0->1->2->3->0.
- Snapshot: on every cycle with cnt==0 and dig==0 (including the first cycle after rst deasserts), frm <= src_pc ? pc_val[15:0] : reg_val[15:0]. Source changes mid-frame are never visible.
- Digit mapping:
  - dig0: AN=0111, nibble frm[15:12].
  - dig1: AN=1011, nibble frm[11:8].
  - dig2: AN=1101, nibble frm[7:4].
  - dig3: AN=1110, nibble frm[3:0].
- Output registers: AN and SSD_out are registered from the current cycle's (cnt, dig, frm) state, so they lag that state by exactly 1 cycle.
  - The snapshot and the dig0/cnt==0 state are presented together one cycle later, so the new frm value is used from the first displayed cycle of dig0.
- Blanking:
  - If cnt < BLANK_CYC: AN=1111 and SSD_out=1111111.
  - Otherwise: the digit's anode pattern above, and SSD_out = hex pattern of the selected nibble.
- Hex patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- frame_done: registered 1-cycle pulse, asserted on the cycle after cnt==TICK_DIV-1 with dig==3. It coincides with the first output cycle of the new frame. Period is exactly 4*TICK_DIV cycles.
- Debounce:
  - sel_raw passes through a 2-flop synchroniser to give s.
  - If s==src_pc, the debounce counter clears.
  - Otherwise the counter increments; when it reaches DEB_CYC, src_pc <= s and the counter clears.
  - Latency from a stable sel_raw edge to src_pc is DEB_CYC+2 cycles.
  - The new source is first used at the next snapshot.
- Simultaneous events: if src_pc updates in the same cycle as a snapshot, the snapshot uses the old src_pc value (registered semantics).
- Counter widths: sized with $clog2 of TICK_DIV and DEB_CYC+1. No overflow past the terminal values.

Test Plan (TICK_DIV=8, BLANK_CYC=2, DEB_CYC=4):
1. Reset mid-scan: assert rst for 3 cycles during dig2.
   -> From the first reset edge: AN=1111, SSD_out=1111111, frame_done=0, src_pc=0.
   -> First non-blank output after release: AN=0111.
2. Scan order: reg_val=0x00001234, sel_raw=0, release rst.
   -> Per slot: 2 cycles of 1111/1111111, then 6 cycles of AN=0111 with SSD_out=1001111 ("1").
   -> Then AN=1011 / 0010010 ("2"), AN=1101 / 0000110 ("3"), AN=1110 / 1001100 ("4").
   -> frame_done pulses every 32 cycles.
3. Snapshot stability: change reg_val to 0x0000ABCD during dig1.
   -> Rest of this frame still shows 2, 3, 4.
   -> Next frame shows 0001000, 1100000, 0110001, 1000010 (A, b, C, d).
4. Debounce glitch: sel_raw high for 3 cycles -> src_pc stays 0.
   Held high with pc_val=0x00400020 -> src_pc=1 exactly 6 cycles after the edge.
   -> The following frame shows 0, 0, 2, 0.
5. Select at snapshot boundary: arrange the src_pc update on the cnt==0, dig==0 cycle.
   -> That frame still shows reg_val; the next frame shows pc_val.
6. BLANK_CYC=0: after the first frame, AN is never 1111 and each digit is active for all 8 cycles.
